// File: rtl/bcd_to_binary_if.sv
// Handshake bundle for the BCD-to-binary converter: word-in / result-out channels.
interface bcd_to_binary_if #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      binary;
  logic                  overflow;
  logic                  bad_digit;

  // Producer / consumer side
  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, binary, overflow, bad_digit
  );

  // Converter side
  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, binary, overflow, bad_digit
  );
endinterface

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to unsigned binary converter, one digit per clock,
// MSD first, Horner accumulation with saturation and sticky overflow.
// Optional nibble validity check enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd_to_binary #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  bcd_to_binary_if.slave bus
);

  localparam int unsigned SR_W  = 4 * DIGITS;
  localparam int unsigned ACC_W = BIN_W + 4;
  localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [BIN_W-1:0]  acc;
  logic [BIN_W-1:0]  bin_q;
  logic [CNT_W-1:0]  cnt;
  logic [SR_W-1:0]   sreg;
  logic              ovf_q;
  logic              bad_q;

  logic [3:0]        nib;
  logic [ACC_W-1:0]  acc_w;
  logic [ACC_W-1:0]  horner;
  logic              step_ovf;
  logic              step_bad;
  logic [BIN_W-1:0]  acc_next;
  logic              ovf_next;
  logic              bad_next;
  logic              last;

  // Horner step on the top nibble; wide enough that acc*10+15 never wraps
  always_comb begin
    nib      = sreg[SR_W-1 -: 4];
    acc_w    = ACC_W'(acc);
    horner   = (acc_w << 3) + (acc_w << 1) + ACC_W'(nib);
    step_ovf = |horner[ACC_W-1:BIN_W];
    acc_next = step_ovf ? '1 : horner[BIN_W-1:0];
`ifdef BCD2BIN_DIGIT_CHECK_EN
    step_bad = (nib > 4'd9);
`else
    step_bad = 1'b0;
`endif
    bad_next = bad_q | step_bad;
    // A bad digit forces the reported overflow low for the whole word
    ovf_next = (ovf_q | step_ovf) & ~bad_next;
    last     = (cnt == CNT_W'(DIGITS - 1));
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      bin_q <= '0;
      cnt   <= '0;
      sreg  <= '0;
      ovf_q <= 1'b0;
      bad_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sreg  <= bus.bcd_in;
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
            bad_q <= 1'b0;
            state <= CONV;
          end
        end
        CONV: begin
          acc   <= acc_next;
          ovf_q <= ovf_next;
          bad_q <= bad_next;
          sreg  <= sreg << 4;
          cnt   <= cnt + 1'b1;
          if (last) begin
            bin_q <= bad_next ? '0 : acc_next;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake decoded from state; result fields straight from registers
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.binary    = bin_q;
  assign bus.overflow  = ovf_q;
  assign bus.bad_digit = bad_q;

endmodule

// File: doc/bcd_to_binary.md
# bcd_to_binary

Sequential converter from packed BCD (decimal digits) to unsigned binary. It is the inverse of the team's binary-to-decimal block. The datapath accepts one packed BCD word per transaction over a valid/ready handshake and processes one digit per clock, most significant first, using Horner accumulation (acc = acc*10 + digit). It presents the saturated binary result with an overflow flag. It sits between decimal front-panel/keypad logic and binary arithmetic datapaths.

## Interface
- DIGITS, 3, number of BCD digits in bcd_in (≥1)
- BIN_W, 8, binary result width (≥4)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  bcd_in valid
- in_ready  output  1  converter can accept a word
- bcd_in  input  4*DIGITS  packed BCD, digit DIGITS-1 in MSBs
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- binary  output  BIN_W  converted value (saturated)
- overflow  output  1  decimal value > 2^BIN_W-1
- bad_digit  output  1  some input nibble > 9 (see Configuration)

## Operation
- FSM states IDLE, CONV, DONE; reset state IDLE.
- IDLE: in_ready=1, out_valid=0. If in_valid, then:
  - capture bcd_in into the digit shift register;
  - clear acc, digit counter, overflow and bad_digit;
  - move to CONV.
- CONV: in_ready=0. Each cycle:
  - new = acc*10 + top nibble, where acc*10 = (acc<<3)+(acc<<1), computed in BIN_W+4 bits (no internal wrap: acc ≤ 2^BIN_W-1, so new ≤ 10*(2^BIN_W-1)+15).
  - If new > 2^BIN_W-1: set the sticky overflow flag and load acc = 2^BIN_W-1. Otherwise load acc = new.
  - Shift the digit register left by 4 and increment the counter.
  - After the DIGITS-th digit, go to DONE.
- DONE: out_valid=1; binary=acc, overflow and bad_digit are held stable. When out_ready is high, move to IDLE.
- in_valid is ignored outside IDLE. No input is captured while busy; the producer holds the word until in_ready.
- out_valid, once asserted, stays high with stable data until out_ready is seen.
- Overflow: binary = all ones, overflow = 1. Example: DIGITS=3, BIN_W=8, input 999 → 0xFF, overflow = 1.

## Timing
- Reset (async assert, sync release) values:
  - state IDLE, in_ready=1, out_valid=0;
  - binary=0, overflow=0, bad_digit=0;
  - acc, counter and shift register all 0.
- Reset asserted mid-CONV or DONE aborts the conversion immediately. The pending result is lost and is never presented.
- Accept at edge T (in_valid && in_ready). CONV occupies edges T+1..T+DIGITS. out_valid is high starting the cycle after edge T+DIGITS; latency is DIGITS cycles from the accept edge.
- The result drains at the edge where out_valid && out_ready. in_ready returns high the following cycle.
- Minimum spacing between accepts is DIGITS+2 cycles; there is no pipelining.
- binary, overflow and bad_digit are registered outputs. in_ready and out_valid are decoded from the state register.

## Configuration
- BCD2BIN_DIGIT_CHECK_EN defined:
  - any nibble > 9 seen during CONV sets sticky bad_digit;
  - at DONE, binary=0 and overflow=0 whenever bad_digit=1;
  - bad_digit is cleared on the next accept.
- Not defined:
  - no check; each nibble is used at its raw value 0–15 in the Horner update;
  - bad_digit is tied 0.
- Port list is identical in both builds.

## Test plan
- DIGITS=3, BIN_W=8, bcd_in=0x255, out_ready=1 → out_valid exactly 3 cycles after the accept edge, binary=0xFF, overflow=0. Then bcd_in=0x000 → binary=0x00, overflow=0.
- bcd_in=0x256 → binary=0xFF, overflow=1. bcd_in=0x999 → binary=0xFF, overflow=1.
- bcd_in=0x1A3:
  - with BCD2BIN_DIGIT_CHECK_EN → bad_digit=1, binary=0x00, overflow=0;
  - without → bad_digit=0, binary=0xCB (100+100+3=203).
- Backpressure: bcd_in=0x128 accepted, out_ready held 0 for 5 cycles → out_valid stays 1, binary=0x80 stable, in_ready=0. During that time in_valid pulses with 0x042 and is not captured. out_ready=1 → drain, then 0x042 accepted → 0x2A.
- Reset: assert rst_n=0 one cycle after accepting 0x123 → all outputs take reset values immediately. After release, in_ready=1 and out_valid never rises for 0x123. A fresh 0x077 gives binary=0x4D.
